// File: rtl/aes_ctrl_pkg.sv
// Shared types and default sizing for the AES core arbiter.
// Holds the control FSM state encoding and default bus width / timeout.
package aes_ctrl_pkg;
  localparam int unsigned DEF_WIDTH   = 128;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins, a tie goes to the pointer.
// Purely combinational, one-hot (or zero) grant.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES cipher core between two requesters, one operation at a time,
// with a BUSY-state timeout that returns an error response instead of hanging.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_key,
  input  logic [WIDTH-1:0] req0_text,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_key,
  input  logic [WIDTH-1:0] req1_text,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic             resp1_err,
  output logic             core_ld,
  output logic [WIDTH-1:0] core_key,
  output logic [WIDTH-1:0] core_text,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_text_out,
  output logic             busy
);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  logic             r_ptr;
  logic             r_gnt;
  logic             r_err;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_key;
  logic [WIDTH-1:0] r_text;
  logic [WIDTH-1:0] r_data;

  logic [1:0]       w_grant;
  logic             w_idle;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_resp_hs;

  rr_arb2 u_rr (
    .i_valid ({req1_valid, req0_valid}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Ready is combinational from valid, so it must be forced low during reset.
  assign w_idle     = (r_state == IDLE) && !rst;
  assign req0_ready = w_idle && w_grant[0];
  assign req1_ready = w_idle && w_grant[1];
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;

  assign resp0_valid = (r_state == RESP) && !r_gnt;
  assign resp1_valid = (r_state == RESP) && r_gnt;
  assign resp0_data  = resp0_valid ? r_data : '0;
  assign resp1_data  = resp1_valid ? r_data : '0;
  assign resp0_err   = resp0_valid && r_err;
  assign resp1_err   = resp1_valid && r_err;
  assign w_resp_hs   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  assign core_ld   = (r_state == LOAD);
  assign core_key  = r_key;
  assign core_text = r_text;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_key   <= '0;
      r_text  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_gnt   <= w_acc1;
            r_key   <= w_acc1 ? req1_key  : req0_key;
            r_text  <= w_acc1 ? req1_text : req0_text;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // Any done seen here belongs to an earlier operation.
          r_cnt   <= '0;
          r_state <= BUSY;
        end
        BUSY: begin
          if (core_done) begin
            r_data  <= core_text_out;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (w_resp_hs) begin
            r_ptr   <= !r_gnt;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: core stub returning key^text after a programmable delay,
// transaction-level reference model for grant order, result value, error and latency.
module tb_aes_core_arbiter;
  localparam int W  = 128;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_key = '0, req0_text = '0, req1_key = '0, req1_text = '0;
  logic         resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [W-1:0] resp0_data, resp1_data;
  logic         core_ld, core_done, busy;
  logic [W-1:0] core_key, core_text, core_text_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic m_ptr = 1'b0;
  int last_g = -1;

  aes_core_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_text(req0_text),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_text(req1_text),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: done rises stub_delay cycles after the core_ld cycle; 0 means never.
  // It ignores rst on purpose so an aborted operation still produces a late done.
  int           stub_delay = 11;
  logic         stub_act   = 1'b0;
  int           stub_cnt   = 0;
  logic [W-1:0] stub_res   = '0;
  logic         stale_done = 1'b0;
  always @(posedge clk) begin
    if (core_ld) begin
      stub_act <= (stub_delay > 0);
      stub_cnt <= stub_delay - 1;
      stub_res <= core_key ^ core_text;
    end else if (stub_act) begin
      if (stub_cnt == 0) stub_act <= 1'b0;
      else stub_cnt <= stub_cnt - 1;
    end
  end
  assign core_done     = (stub_act && stub_cnt == 0) || stale_done;
  assign core_text_out = stub_res;

  wire [11:0] w_outs = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err,
                        core_ld, busy, |resp0_data, |resp1_data, |core_key, |core_text};

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One complete transaction, checked against the model: grant, core_ld count,
  // response cycle, data/err, stability while stalled, back-pressure, return to IDLE.
  task automatic run_txn(input logic [1:0] vld, input logic [W-1:0] k0, input logic [W-1:0] t0,
                         input logic [W-1:0] k1, input logic [W-1:0] t1,
                         input int d, input int hold, input bit stale, input string tag);
    int g, t_acc, t_exp, n_ld, waited;
    bit seen, bp_bad, unstable, ok_done;
    logic [W-1:0] exp_dat, cap_dat;
    logic exp_err, cap_err, gv;
    g = (vld == 2'b11) ? int'(m_ptr) : (vld[1] ? 1 : 0);
    ok_done = (d >= 1) && (d <= TO);
    exp_dat = ok_done ? ((g == 1) ? (k1 ^ t1) : (k0 ^ t0)) : '0;
    exp_err = !ok_done;

    @(negedge clk);
    stub_delay = d;
    req0_valid = vld[0]; req1_valid = vld[1];
    req0_key = k0; req0_text = t0; req1_key = k1; req1_text = t1;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin
      n_bad++;
      $display("FAIL %s grant: ready=%b expected %b", tag, {req1_ready, req0_ready}, (g == 1) ? 2'b10 : 2'b01);
    end
    last_g = req1_ready ? 1 : (req0_ready ? 0 : -1);
    t_acc = cyc;
    t_exp = ok_done ? (t_acc + d + 2) : (t_acc + TO + 2);

    @(negedge clk);
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (stale) stale_done = 1'b1;
    n_cmp++;
    if (core_ld !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s load: core_ld=%b busy=%b expected 1 1", tag, core_ld, busy);
    end
    n_ld = 1;
    seen = 0; waited = 0; bp_bad = 0; unstable = 0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      stale_done = 1'b0;
      waited++;
      if (core_ld === 1'b1) n_ld++;
      gv = (g == 0) ? resp0_valid : resp1_valid;
      if (gv === 1'b1) seen = 1;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bp_bad = 1;
      if (((g == 0) ? resp1_valid : resp0_valid) !== 1'b0) bp_bad = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s resp_wait: no response within 300 cycles", tag);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    n_cmp++;
    if (cyc !== t_exp) begin
      n_bad++;
      $display("FAIL %s resp_cycle: got %0d need %0d", tag, cyc - t_acc, t_exp - t_acc);
    end
    cap_dat = (g == 0) ? resp0_data : resp1_data;
    cap_err = (g == 0) ? resp0_err  : resp1_err;
    n_cmp++;
    if (cap_dat !== exp_dat || cap_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s resp_data: data=%h err=%b need data=%h err=%b", tag, cap_dat, cap_err, exp_dat, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (core_ld === 1'b1) n_ld++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bp_bad = 1;
      if (((g == 0) ? resp0_valid : resp1_valid) !== 1'b1) unstable = 1;
      if (((g == 0) ? resp0_data : resp1_data) !== cap_dat) unstable = 1;
      if (((g == 0) ? resp0_err : resp1_err) !== cap_err) unstable = 1;
    end
    if (g == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s to_idle: busy=%b v0=%b v1=%b expected 0 0 0", tag, busy, resp0_valid, resp1_valid);
    end
    n_cmp++;
    if (n_ld !== 1) begin
      n_bad++;
      $display("FAIL %s ld_count: got %0d need 1", tag, n_ld);
    end
    n_cmp++;
    if (bp_bad || unstable) begin
      n_bad++;
      $display("FAIL %s hold: backpressure_violation=%0d unstable=%0d need 0 0", tag, bp_bad, unstable);
    end
    m_ptr = (g == 0) ? 1'b1 : 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (w_outs !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b need all 0", w_outs);
    end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || core_ld !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%b core_ld=%b need 0 0", busy, core_ld);
    end
    m_ptr = 1'b0;
  endtask

  task automatic test_back_to_back;
    int exp_seq [4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, rnd128(), rnd128(), rnd128(), rnd128(), 11, 0, 0, "b2b");
      n_cmp++;
      if (last_g !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL b2b_order[%0d]: granted %0d need %0d", i, last_g, exp_seq[i]);
      end
    end
  endtask

  task automatic test_single;
    run_txn(2'b01, 128'hcafebabedeadbeefdeadbeef00000000, 128'hE5E9186FA729469697547738A3E2ABF5,
            rnd128(), rnd128(), 11, 0, 0, "single0");
    run_txn(2'b10, rnd128(), rnd128(), rnd128(), rnd128(), 11, 0, 0, "single1");
  endtask

  task automatic test_timeout;
    run_txn(2'b01, rnd128(), rnd128(), rnd128(), rnd128(), 0, 0, 0, "timeout");
    run_txn(2'b10, rnd128(), rnd128(), rnd128(), rnd128(), TO, 0, 0, "done_at_last");
    run_txn(2'b01, rnd128(), rnd128(), rnd128(), rnd128(), TO + 1, 0, 0, "done_too_late");
    run_txn(2'b10, rnd128(), rnd128(), rnd128(), rnd128(), 1, 0, 0, "done_first_busy");
  endtask

  task automatic test_stall;
    run_txn(2'b11, rnd128(), rnd128(), rnd128(), rnd128(), 11, 20, 0, "stall");
  endtask

  task automatic test_stale_done;
    run_txn(2'b01, rnd128(), rnd128(), rnd128(), rnd128(), 11, 0, 1, "stale_done");
  endtask

  task automatic test_reset_mid_op;
    bit leak;
    run_txn(2'b01, rnd128(), rnd128(), rnd128(), rnd128(), 11, 0, 0, "pre_rst");
    @(negedge clk);
    stub_delay = 11;
    req0_valid = 1'b1; req0_key = rnd128(); req0_text = rnd128();
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_busy: busy=%b need 1", busy);
    end
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if (w_outs !== 12'b0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %b need all 0", w_outs);
    end
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    leak = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0) leak = 1;
    end
    n_cmp++;
    if (leak) begin
      n_bad++;
      $display("FAIL rst_late_done: response or busy seen after reset, need none");
    end
    m_ptr = 1'b0;
    run_txn(2'b11, rnd128(), rnd128(), rnd128(), rnd128(), 11, 0, 0, "post_rst");
    n_cmp++;
    if (last_g !== 0) begin
      n_bad++;
      $display("FAIL post_rst_ptr: granted %0d need 0", last_g);
    end
  endtask

  task automatic test_random;
    logic [1:0] v;
    int d;
    for (int i = 0; i < 25; i++) begin
      v = 2'($urandom_range(1, 3));
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 1));
      run_txn(v, rnd128(), rnd128(), rnd128(), rnd128(), d, int'($urandom_range(0, 5)), 0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_single;
    test_timeout;
    test_stall;
    test_stale_done;
    test_reset_mid_op;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
